pin_debounce: RTL
=================

PIN_DEBOUNCE -- requirements
Module: pin_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on pin (legal 2..4).
REQ-002 Parameter CNT_W, default 16, debounce counter and PERIOD width (legal 4..24).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset; assertion clears all state immediately.
REQ-005 valid  input  1  bus request; held by master until ready seen.
REQ-006 ready  output  1  bus acknowledge, one-cycle pulse.
REQ-007 wstrb  input  4  byte write strobes; all-zero = read.
REQ-008 addr  input  32  byte address; only addr[3:2] decoded.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  read data, valid while ready=1.
REQ-011 pin  input  1  raw asynchronous external input.
REQ-012 in_clean  output  1  debounced level; drives the downstream register block's in port.
REQ-013 irq  output  1  registered level interrupt.

Function
REQ-014 Register map: 0x0 STATUS [0]=level RO, [1]=rise flag W1C, [2]=fall flag W1C; 0x4 PERIOD [CNT_W-1:0] RW; 0x8 CTRL [0]=en, [1]=rise_ie, [2]=fall_ie RW; 0xC COUNT [CNT_W-1:0] RO.
REQ-015 Unimplemented bits read 0; writes to RO fields ignored.
REQ-016 Transaction accepted in a cycle with valid=1 and ready=0; ready=1 the following cycle for exactly one cycle, then 0 even if valid still high.
REQ-017 Write takes effect at acceptance edge, per byte lane gated by wstrb[i]; rdata captured at acceptance edge from pre-write register values.
REQ-018 pin passes through SYNC_STAGES flops; result is sync.
REQ-019 When en=1 and sync != level: count increments by 1 per cycle; when count == PERIOD, level <= sync and count <= 0 in that same edge.
REQ-020 When en=1 and sync == level: count <= 0 (glitch shorter than PERIOD+1 cycles rejected).
REQ-021 PERIOD=0: level follows sync one cycle after it differs.
REQ-022 PERIOD written mid-count: new value compared from next cycle; if count already > new PERIOD, level updates next cycle and count clears.
REQ-023 count saturates at 2^CNT_W-1, never wraps.
REQ-024 When en=0: count held at 0, level frozen, flags retained and still W1C-clearable.
REQ-025 level 0->1 sets rise flag; 1->0 sets fall flag; set in the same edge level changes.
REQ-026 Set and W1C on the same flag in the same cycle: set wins.
REQ-027 in_clean = level (registered, no combinational path from pin).
REQ-028 irq <= (rise & rise_ie) | (fall & fall_ie), one cycle after the contributing flag/enable.

Reset
REQ-029 On resetn=0: ready=0, rdata=0, sync flops=0, level=0, in_clean=0, count=0, flags=0, irq=0, PERIOD=16, CTRL=0x1 (en=1, irqs off).
REQ-030 Reset asserted mid-transaction aborts it; no ready pulse after release for the aborted request.
REQ-031 Reset asserted mid-count discards the pending change; no flag set.

Verification
REQ-032 Reset, hold pin=1, PERIOD=16 -> in_clean rises exactly SYNC_STAGES+17 cycles after pin edge; STATUS reads 0x3.
REQ-033 pin=1 pulse of 10 cycles with PERIOD=16 -> in_clean stays 0, COUNT returns 0, no flags.
REQ-034 CTRL=0x7, debounced 1->0 transition -> fall flag set, irq=1 next cycle; write STATUS=0x4 -> irq=0 one cycle after flag clears.
REQ-035 W1C of rise flag in the same cycle level rises -> flag remains 1.
REQ-036 Write PERIOD=0x1234 with wstrb=0b0001 -> PERIOD reads 0x0034 (upper byte unchanged from 0x00); ready pulses once per request while valid held 3 cycles.
REQ-037 CTRL=0 (en=0), toggle pin for 50 cycles -> in_clean and COUNT unchanged; re-enable -> debounce resumes from count 0.

Source files
------------

// File: rtl/pin_debounce.sv
// pin_debounce
// Debounces one raw external pin and exposes its state, edge flags and
// debounce timing through a small four-register bus slave.
//
// Register map (byte offsets, addr[3:2] decoded, higher bits ignored):
//   0x0 STATUS  [0] level (RO), [1] rise flag (W1C), [2] fall flag (W1C)
//   0x4 PERIOD  [CNT_W-1:0] debounce period (RW)
//   0x8 CTRL    [0] en, [1] rise_ie, [2] fall_ie (RW)
//   0xC COUNT   [CNT_W-1:0] current debounce count (RO)
//
// The debounced level changes only after the synchronized pin has disagreed
// with it for PERIOD+1 consecutive cycles. Any cycle of agreement restarts
// that count, so shorter glitches never reach in_clean.
module pin_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        pin,
  output logic        in_clean,
  output logic        irq
);

  localparam logic [1:0]       SEL_STATUS = 2'd0;
  localparam logic [1:0]       SEL_PERIOD = 2'd1;
  localparam logic [1:0]       SEL_CTRL   = 2'd2;
  localparam logic [1:0]       SEL_COUNT  = 2'd3;
  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(16);
  localparam logic [CNT_W-1:0] COUNT_MAX  = '1;

  // synchronizer chain; bit 0 samples the raw pin
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;

  // debounce state
  logic             level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise_set, fall_set;

  // software-visible registers
  logic [CNT_W-1:0] period_q, period_d;
  logic             en_q, en_d;
  logic             rise_ie_q, rise_ie_d;
  logic             fall_ie_q, fall_ie_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             irq_q, irq_d;

  // bus handshake and read path
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             accept;
  logic [1:0]       reg_sel;
  logic [31:0]      byte_mask;
  logic             status_wr;
  logic             period_wr;
  logic             ctrl_wr;
  logic [31:0]      rd_mux;

  // address bits above the word index and below it carry no meaning here
  logic             unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wdata, byte_mask};

  assign sync     = sync_q[SYNC_STAGES-1];
  assign reg_sel  = addr[3:2];
  assign accept   = valid & ~ready_q;

  assign byte_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};

  // Only lane 0 holds STATUS and CTRL bits, so their writes need wstrb[0].
  assign status_wr = accept & (reg_sel == SEL_STATUS) & wstrb[0];
  assign period_wr = accept & (reg_sel == SEL_PERIOD);
  assign ctrl_wr   = accept & (reg_sel == SEL_CTRL) & wstrb[0];

  assign ready    = ready_q;
  assign rdata    = rdata_q;
  assign in_clean = level_q;
  assign irq      = irq_q;

  // Shift the raw pin through the synchronizer; only the last stage is used.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
  end

  // Debounce: count disagreeing cycles and adopt the new level once the
  // count has reached PERIOD. Using >= lets a PERIOD lowered below the
  // running count take effect on the very next cycle.
  always_comb begin
    level_d  = level_q;
    count_d  = count_q;
    rise_set = 1'b0;
    fall_set = 1'b0;
    if (!en_q) begin
      count_d = '0;
    end else if (sync == level_q) begin
      count_d = '0;
    end else if (count_q >= period_q) begin
      level_d  = sync;
      count_d  = '0;
      rise_set = sync;
      fall_set = ~sync;
    end else if (count_q != COUNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Edge flags: software clears with write-one, but a new edge in the same
  // cycle must not be lost, so the set is applied last.
  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    if (status_wr && wdata[1]) begin
      rise_d = 1'b0;
    end
    if (status_wr && wdata[2]) begin
      fall_d = 1'b0;
    end
    if (rise_set) begin
      rise_d = 1'b1;
    end
    if (fall_set) begin
      fall_d = 1'b1;
    end
  end

  // PERIOD and CTRL writes, merged byte lane by byte lane.
  always_comb begin
    period_d  = period_q;
    en_d      = en_q;
    rise_ie_d = rise_ie_q;
    fall_ie_d = fall_ie_q;
    if (period_wr) begin
      period_d = (period_q & ~byte_mask[CNT_W-1:0]) |
                 (wdata[CNT_W-1:0] & byte_mask[CNT_W-1:0]);
    end
    if (ctrl_wr) begin
      en_d      = wdata[0];
      rise_ie_d = wdata[1];
      fall_ie_d = wdata[2];
    end
  end

  // Interrupt is built from the registered flags so it lags them by a cycle.
  always_comb begin
    irq_d = (rise_q & rise_ie_q) | (fall_q & fall_ie_q);
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      SEL_STATUS: rd_mux = {29'd0, fall_q, rise_q, level_q};
      SEL_PERIOD: rd_mux = 32'(period_q);
      SEL_CTRL:   rd_mux = {29'd0, fall_ie_q, rise_ie_q, en_q};
      SEL_COUNT:  rd_mux = 32'(count_q);
      default:    rd_mux = '0;
    endcase
  end

  // Handshake: one ready pulse per accepted request; rdata is only
  // meaningful while ready is high and reads as zero otherwise.
  always_comb begin
    ready_d = accept;
    rdata_d = accept ? rd_mux : 32'd0;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Debounce level and counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  // Configuration registers, edge flags and interrupt output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_q  <= PERIOD_RST;
      en_q      <= 1'b1;
      rise_ie_q <= 1'b0;
      fall_ie_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      period_q  <= period_d;
      en_q      <= en_d;
      rise_ie_q <= rise_ie_d;
      fall_ie_q <= fall_ie_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      irq_q     <= irq_d;
    end
  end

  // Bus response registers; reset drops any request in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
